// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch and data load/store requesters. One transaction is
// outstanding at a time. Data has priority, but a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants while fetch waited.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              err_stray
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            state, state_nxt;
   logic              grant_d, grant_f;
   logic              owner_d;          // 1 = data requester owns the transaction
   logic [3:0]        starve_cnt;
   logic              req_we_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Arbitration, next state and handshake outputs
   always_comb begin
      state_nxt     = state;
      grant_d       = 1'b0;
      grant_f       = 1'b0;
      mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            if (d_req_valid && !(if_req_valid && starve_cnt == STARVE_LIM))
               grant_d = 1'b1;
            else if (if_req_valid)
               grant_f = 1'b1;
            if (grant_d || grant_f) state_nxt = REQ;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = RESP;
         end
         RESP: begin
            if (mem_resp_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Ready must read 0 while reset is held, even though the state already sits in IDLE
      d_req_ready  = grant_d && !rst;
      if_req_ready = grant_f && !rst;
   end

   // Request capture on the accept edge, plus starvation bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         owner_d     <= 1'b0;
         starve_cnt  <= '0;
      end else if (grant_d) begin
         req_we_q    <= d_req_we;
         req_addr_q  <= d_req_addr;
         req_wdata_q <= d_req_wdata;
         owner_d     <= 1'b1;
         if (!if_req_valid)                starve_cnt <= '0;
         else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else if (grant_f) begin
         req_we_q    <= 1'b0;
         req_addr_q  <= if_req_addr;
         req_wdata_q <= '0;
         owner_d     <= 1'b0;
         starve_cnt  <= '0;
      end
   end

   assign mem_req_we    = req_we_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_wdata = req_wdata_q;

   // Route the memory response back to the owner as a one-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         d_resp_valid  <= 1'b0;
         d_resp_data   <= '0;
      end else begin
         if_resp_valid <= 1'b0;
         d_resp_valid  <= 1'b0;
         if (state == RESP && mem_resp_valid) begin
            if (owner_d) begin
               d_resp_valid <= 1'b1;
               d_resp_data  <= req_we_q ? '0 : mem_resp_data;
            end else begin
               if_resp_valid <= 1'b1;
               if_resp_data  <= mem_resp_data;
            end
         end
      end
   end

   // Sticky flag for responses arriving when none is outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  err_stray <= 1'b0;
      else if (mem_resp_valid && state != RESP) err_stray <= 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [63:0] if_resp_data;
   logic        d_req_valid;
   logic        d_req_we;
   logic [63:0] d_req_addr;
   logic [63:0] d_req_wdata;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [63:0] d_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        err_stray;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
      .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
      .if_resp_data(if_resp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .err_stray(err_stray)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From REQ: memory takes the request at once and answers in the next cycle
   task automatic serve(input logic [63:0] rdata);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      tick();
      mem_resp_valid = 1'b0;
   endtask

   logic exp_d;

   initial begin
      rst = 1'b1;
      if_req_valid = 1'b1; if_req_addr = 64'h0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h0; d_req_wdata = 64'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
      tick(); tick();

      // Reset state: everything 0 even with both requesters valid
      chk("rst_if_ready",  if_req_ready,  0);
      chk("rst_d_ready",   d_req_ready,   0);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_if_rvalid", if_resp_valid, 0);
      chk("rst_d_rvalid",  d_resp_valid,  0);
      chk("rst_err",       err_stray,     0);
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick();

      // 1: fetch only, minimum latency
      if_req_valid = 1'b1; if_req_addr = 64'h100;
      #1;
      chk("t1_if_ready", if_req_ready, 1);
      chk("t1_d_ready",  d_req_ready,  0);
      tick();
      if_req_valid = 1'b0;
      chk("t1_mem_valid", mem_req_valid, 1);
      chk("t1_mem_addr",  mem_req_addr,  64'h100);
      chk("t1_mem_we",    mem_req_we,    0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("t1_resp_mem_valid", mem_req_valid, 0);
      mem_resp_valid = 1'b1; mem_resp_data = 64'h13;
      tick();
      mem_resp_valid = 1'b0;
      chk("t1_if_rvalid", if_resp_valid, 1);
      chk("t1_if_rdata",  if_resp_data,  64'h13);
      chk("t1_d_rvalid",  d_resp_valid,  0);
      tick();
      chk("t1_if_pulse_end", if_resp_valid, 0);

      // 2: simultaneous requests, data first
      if_req_valid = 1'b1; if_req_addr = 64'h200;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h80;
      #1;
      chk("t2_d_ready",  d_req_ready,  1);
      chk("t2_if_ready", if_req_ready, 0);
      tick();
      d_req_valid = 1'b0;
      chk("t2_mem_addr_d",   mem_req_addr, 64'h80);
      chk("t2_if_ready_req", if_req_ready, 0);
      serve(64'h55);
      chk("t2_d_rvalid",  d_resp_valid,  1);
      chk("t2_d_rdata",   d_resp_data,   64'h55);
      chk("t2_if_rvalid", if_resp_valid, 0);
      chk("t2_if_b2b_ready", if_req_ready, 1);
      tick();
      if_req_valid = 1'b0;
      chk("t2_mem_addr_f", mem_req_addr, 64'h200);
      serve(64'h93);
      chk("t2_if_rvalid2", if_resp_valid, 1);
      chk("t2_if_rdata2",  if_resp_data,  64'h93);

      // 3: store
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h40; d_req_wdata = 64'hDEADBEEF;
      #1;
      chk("t3_d_ready", d_req_ready, 1);
      tick();
      d_req_valid = 1'b0;
      chk("t3_mem_we",    mem_req_we,    1);
      chk("t3_mem_addr",  mem_req_addr,  64'h40);
      chk("t3_mem_wdata", mem_req_wdata, 64'hDEADBEEF);
      serve(64'h1234);
      chk("t3_d_rvalid", d_resp_valid, 1);
      chk("t3_d_rdata",  d_resp_data,  64'h0);

      // 4: starvation, expected grants D,D,D,D,F,D,D,D,D,F
      d_req_we = 1'b0; d_req_addr = 64'h900; if_req_addr = 64'hA00;
      if_req_valid = 1'b1; d_req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_d = !(i == 4 || i == 9);
         #1;
         chk($sformatf("t4_d_ready_%0d", i),  d_req_ready,  exp_d);
         chk($sformatf("t4_if_ready_%0d", i), if_req_ready, !exp_d);
         tick();
         chk($sformatf("t4_addr_%0d", i), mem_req_addr, exp_d ? 64'h900 : 64'hA00);
         serve(64'h7 + i);
         chk($sformatf("t4_rvalid_%0d", i), exp_d ? d_resp_valid : if_resp_valid, 1);
      end
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      tick();

      // 5: backpressure on a store while fetch waits
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h300; d_req_wdata = 64'hCAFE;
      if_req_valid = 1'b1; if_req_addr = 64'h700;
      #1;
      chk("t5_d_ready", d_req_ready, 1);
      tick();
      d_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_valid_%0d", i), mem_req_valid, 1);
         chk($sformatf("t5_addr_%0d", i),  mem_req_addr,  64'h300);
         chk($sformatf("t5_wdata_%0d", i), mem_req_wdata, 64'hCAFE);
         chk($sformatf("t5_rdy_%0d", i),   {if_req_ready, d_req_ready}, 0);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("t5_resp_mem_valid", mem_req_valid, 0);
      chk("t5_resp_if_ready",  if_req_ready,  0);
      mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF;
      tick();
      mem_resp_valid = 1'b0; if_req_valid = 1'b0;
      chk("t5_d_rvalid", d_resp_valid, 1);
      chk("t5_d_rdata",  d_resp_data,  64'h0);
      chk("t5_err",      err_stray,    0);
      tick();

      // 6: reset in RESP, then a stray response
      if_req_valid = 1'b1; if_req_addr = 64'h500;
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_if_ready", if_req_ready,  0);
      chk("t6_rst_mem_addr", mem_req_addr,  64'h0);
      chk("t6_rst_valid",    mem_req_valid, 0);
      if_req_valid = 1'b0;
      #2 rst = 1'b0;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
      tick();
      mem_resp_valid = 1'b0;
      chk("t6_err",       err_stray,     1);
      chk("t6_if_rvalid", if_resp_valid, 0);
      chk("t6_d_rvalid",  d_resp_valid,  0);
      tick();
      chk("t6_err_sticky", err_stray,     1);
      chk("t6_if_rvalid2", if_resp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Safety net: the directed sequence is short
   initial begin
      #100000;
      $display("FAIL timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name:
mem_port_arbiter

Overview:
Shares one single-ported memory between the core's instruction-fetch requester and its data load/store requester. The shared memory has variable latency and a valid/ready request channel. The arbiter grants one requester at a time and keeps at most one transaction outstanding. It registers the request, sequences it to memory, and routes the response back to the owner. It sits between the RV64 core's PC_IMEM/DMEM-side fetch and load/store logic and the unified memory; the core stalls on the ready and response-valid handshakes.

Parameters:
ADDR_W, 64, address width of all request channels
DATA_W, 64, data width; fetch uses resp_data[31:0] as the instruction
STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced (range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_W  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_resp_valid  out  1  one-cycle pulse: fetch data valid
if_resp_data  out  DATA_W  fetch data
d_req_valid  in  1  data request
d_req_we  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  DATA_W  store data
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  one-cycle pulse: load data valid or store complete
d_resp_data  out  DATA_W  load data (0 for stores)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  write enable
mem_req_addr  out  ADDR_W  memory address
mem_req_wdata  out  DATA_W  write data
mem_resp_valid  in  1  memory response (read data or write ack)
mem_resp_data  in  DATA_W  memory read data
err_stray  out  1  sticky: mem_resp_valid seen outside RESP

Behaviour:
- Clock and reset: clk, with rst asynchronous active-high. While rst=1 the FSM is forced to IDLE and the starve counter to 0. All outputs are 0: *_ready, *_resp_valid, *_resp_data, mem_req_*, err_stray.
- FSM states: IDLE, REQ, RESP.
- IDLE
  - Grant is computed combinationally from the valid inputs.
  - Priority is data over fetch, except: if if_req_valid=1 and starve_cnt==STARVE_MAX, fetch wins.
  - The granted requester's *_ready=1 in the same cycle; the other requester's ready=0. If neither is valid, both ready=0.
  - On the accept edge: addr, we, wdata and owner are captured into registers, and the FSM goes to REQ.
  - Fetch requests capture we=0 and wdata=0.
- REQ
  - mem_req_valid=1 with the registered fields. These fields stay stable until mem_req_ready=1.
  - On valid&ready the FSM goes to RESP. Backpressure of any length is tolerated.
- RESP
  - mem_req_valid=0.
  - On mem_resp_valid=1: the owner's resp_valid pulses high on the next cycle for exactly one cycle. resp_data is registered from mem_resp_data, or is 0 for stores. The FSM returns to IDLE on that same edge.
  - The non-owner's resp_valid stays 0.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, and with mem ready in N+1 plus response in N+2, resp_valid at N+3.
- A new request may be accepted in the same cycle resp_valid is high (back-to-back).
- Starve counter (4-bit), updated on each grant:
  - data grant with if_req_valid=1: cnt+1, saturating at STARVE_MAX
  - data grant with if_req_valid=0: cnt cleared to 0
  - fetch grant: cnt cleared to 0
- Resp_data holds its last value between pulses; it is don't-care for checking when resp_valid=0.
- err_stray is set on mem_resp_valid=1 in IDLE or REQ and cleared only by rst. A stray response never produces a resp_valid pulse.
- Reset mid-transaction aborts the transaction. No resp_valid is produced, and the requester must reissue.
- Requesters must hold valid and payload until ready; dropping valid before ready is legal and simply loses arbitration.

Test Plan:
1. Fetch only: if_req_addr=0x100 accepted at cycle 1; mem_req_ready=1 at cycle 2; mem_resp_data=0x00000013 at cycle 3 -> if_resp_valid=1 with data 0x13 at cycle 4, d_resp_valid stays 0.
2. Simultaneous requests: fetch at 0x200 and data load at 0x80 both valid in IDLE -> d_req_ready=1 and if_req_ready=0. mem_req_addr=0x80 first, then 0x200 after the data response.
3. Store: d_req_we=1, addr 0x40, wdata 0xDEADBEEF -> mem_req_we=1 with matching wdata; after the ack, d_resp_valid=1 and d_resp_data=0.
4. Starvation with STARVE_MAX=4: fetch and data continuously valid -> grant order D,D,D,D,F,D,D,D,D,F.
5. Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid, addr and wdata stable all 5 cycles; no new ready issued to either requester.
6. Reset and stray response: rst=1 while in RESP -> outputs 0 immediately (asynchronous); a later mem_resp_valid=1 in IDLE -> err_stray=1 and no resp_valid pulse.
